// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, latencies and helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 16;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational 64-bit multiply/divide result generator.
module mdu_calc
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  MduOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] Result,
  output logic        DivByZero
);

  logic        b_zero;
  logic        ovf;
  logic [31:0] b_u;
  logic [31:0] b_s;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign b_zero = (B == 32'd0);
  assign ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Dividing the overflow case by +1 yields the required 0x80000000 rem 0.
  assign b_u = b_zero ? 32'd1 : B;
  assign b_s = (b_zero || ovf) ? 32'd1 : B;

  assign prod_s = $unsigned($signed({{32{A[31]}}, A}) *
                            $signed({{32{B[31]}}, B}));
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign q_s = $unsigned($signed(A) / $signed(b_s));
  assign r_s = $unsigned($signed(A) % $signed(b_s));
  assign q_u = A / b_u;
  assign r_u = A % b_u;

  always_comb begin
    Result    = '0;
    DivByZero = is_div(MduOp) && b_zero;
    unique case (MduOp)
      MDU_MULT:  Result = prod_s;
      MDU_MULTU: Result = prod_u;
      MDU_DIV:   Result = {r_s, q_s};
      MDU_DIVU:  Result = {r_u, q_u};
      default:   Result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO architectural registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MultCycles = MDU_MULT_CYCLES,
  parameter int DivCycles  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MduOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [MDU_CNT_W-1:0] MulN = MultCycles[MDU_CNT_W-1:0];
  localparam logic [MDU_CNT_W-1:0] DivN = DivCycles[MDU_CNT_W-1:0];

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]          pend_q, pend_d;
  logic                 dz_q, dz_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;

  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .MduOp     (MduOp),
    .A         (A),
    .B         (B),
    .Result    (calc_res),
    .DivByZero (calc_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (is_muldiv(MduOp)) begin
            pend_d  = calc_res;
            dz_d    = calc_dz;
            cnt_d   = is_div(MduOp) ? DivN : MulN;
            state_d = S_RUN;
          end else if (MduOp == MDU_MTHI) begin
            hi_d = A;
          end else if (MduOp == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // Start is ignored here; only the final count commits.
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: cycle-accurate behavioural model plus directed pins.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MduOp = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mult_div_unit #(.MultCycles(MC), .DivCycles(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MduOp (MduOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: architectural HI/LO, plus the cycle index at which a
  // pending result lands. Busy holds while cyc < done_at.
  int          cyc = 0;
  int          done_at = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          p_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)",
                  name, got, exp, $time);
  endtask

  task automatic model_edge();
    longint sa, sb;
    longint unsigned ua, ub, pu;
    longint ps, q, r;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    ua = {32'd0, A};
    ub = {32'd0, B};
    if (reset) begin
      m_hi = '0; m_lo = '0; done_at = 0; p_ok = 1'b0;
    end else if (cyc < done_at) begin
      if (cyc + 1 == done_at && p_ok) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (Start) begin
      case (MduOp)
        MDU_MULT: begin
          ps = sa * sb;
          p_hi = ps[63:32]; p_lo = ps[31:0]; p_ok = 1'b1;
          done_at = cyc + MC + 1;
        end
        MDU_MULTU: begin
          pu = ua * ub;
          p_hi = pu[63:32]; p_lo = pu[31:0]; p_ok = 1'b1;
          done_at = cyc + MC + 1;
        end
        MDU_DIV: begin
          p_ok = (B != 0);
          if (p_ok) begin
            q = sa / sb; r = sa % sb;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
          done_at = cyc + DC + 1;
        end
        MDU_DIVU: begin
          p_ok = (B != 0);
          if (p_ok) begin
            p_lo = 32'(ua / ub); p_hi = 32'(ua % ub);
          end
          done_at = cyc + DC + 1;
        end
        MDU_MTHI: m_hi = A;
        MDU_MTLO: m_lo = A;
        default: ;
      endcase
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    Start = 1'b1; MduOp = op; A = a; B = b;
    tick();
    Start = 1'b0; MduOp = 3'd7; A = $urandom; B = $urandom;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, Busy}, {31'd0, (cyc < done_at)});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  initial begin
    idle(1);
    chk_en = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    idle(4);
    check("mult_busy5", {31'd0, Busy}, 32'd1);
    check("mult_hold_hi", HI, 32'd0);
    tick();
    check("mult_done", {31'd0, Busy}, 32'd0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    check("div_busy10", {31'd0, Busy}, 32'd1);
    tick();
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0);

    issue(MDU_MTHI, 32'h1234, 32'd0);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    check("mthi_hi", HI, 32'h1234);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo", LO, 32'h5678);
    issue(MDU_DIVU, 32'd99, 32'd0);
    idle(9);
    check("dz_busy", {31'd0, Busy}, 32'd1);
    tick();
    check("dz_hi", HI, 32'h1234);
    check("dz_lo", LO, 32'h5678);

    issue(MDU_DIV, 32'd100, 32'd7);
    idle(3);
    issue(MDU_MTHI, 32'hAAAA, 32'd0);
    idle(7);
    check("ign_hi", HI, 32'd2);
    check("ign_lo", LO, 32'd14);

    issue(MDU_DIV, 32'd50, 32'd3);
    idle(2);
    reset = 1'b1;
    Start = 1'b1; MduOp = MDU_MTHI; A = 32'h5555;
    tick();
    reset = 1'b0; Start = 1'b0;
    check("rr_busy", {31'd0, Busy}, 32'd0);
    check("rr_hi", HI, 32'd0);
    check("rr_lo", LO, 32'd0);

    issue(MDU_MULT, 32'd3, 32'd4);
    idle(5);
    check("b2b_idle", {31'd0, Busy}, 32'd0);
    check("b2b_lo1", LO, 32'd12);
    issue(MDU_MULT, 32'd5, 32'd6);
    check("b2b_acc", {31'd0, Busy}, 32'd1);
    idle(5);
    check("b2b_lo2", LO, 32'd30);

    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom_range(0, 2) == 0);
      MduOp = 3'($urandom_range(0, 7));
      A = $urandom;
      B = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 19) == 0) begin
        A = 32'h8000_0000; B = 32'hFFFF_FFFF;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; Start = 1'b0;
    idle(DC + 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
